// File: rtl/mux_pkg.sv
// Shared mode encodings and select-width helper for the registered N-to-1 mux.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // A single-channel mux still needs a 1-bit select port.
  function automatic int calc_selw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant search from ptr upward with wrap; owns ptr and advances it past each used grant.
// Latency: grant is combinational from req and ptr; ptr moves one edge after en.
// Backpressure: en is only raised by the caller when a grant was actually consumed.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int N    = 4,
  localparam int SELW = calc_selw(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            en,
  output logic [SELW-1:0] grant,
  output logic            grant_valid
);

  logic [SELW-1:0] ptr_q;
  logic [SELW-1:0] ptr_d;
  int              idx;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= N) idx = idx - N;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant       = SELW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (en) begin
      ptr_d = (grant == SELW'(N - 1)) ? '0 : SELW'(grant + 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mux_nto1_reg.sv
// N-to-1 registered mux with per-channel valid/ready; round-robin mode only when MUX_RR_MODE_EN is defined.
// Latency: 1 cycle from accept to out_valid; 1 word/cycle with out_ready held high.
// Backpressure: register loads only when empty or draining; otherwise every in_ready is low.
module mux_nto1_reg
  import mux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SELW  = calc_selw(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SELW-1:0]    sel,
  input  logic               mode,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_src,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_src_q, out_src_d;
  logic             out_valid_q, out_valid_d;

  logic             load_en;
  logic             sel_vld;
  logic [SELW-1:0]  grant_idx;
  logic             grant_vld;
  logic             xfer;
  logic [WIDTH-1:0] picked;

  // Gating with rst_n keeps in_ready low while held in reset.
  assign load_en = rst_n && (!out_valid_q || out_ready);
  assign xfer    = load_en && grant_vld;

  // Out-of-range select values simply match no channel.
  always_comb begin
    sel_vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SELW'(i)) sel_vld = in_valid[i];
    end
  end

`ifdef MUX_RR_MODE_EN
  logic [SELW-1:0] rr_grant;
  logic            rr_vld;
  logic            use_rr;

  assign use_rr = (mode == MODE_RR);

  rr_arbiter #(.N(N)) u_rr (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (in_valid),
    .en          (xfer && use_rr),
    .grant       (rr_grant),
    .grant_valid (rr_vld)
  );

  assign grant_idx = use_rr ? rr_grant : sel;
  assign grant_vld = use_rr ? rr_vld   : sel_vld;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign grant_idx   = sel;
  assign grant_vld   = sel_vld;
`endif

  always_comb begin
    in_ready = '0;
    picked   = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SELW'(i)) begin
        in_ready[i] = xfer;
        picked      = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (load_en) begin
      out_valid_d = grant_vld;
      if (grant_vld) begin
        out_data_d = picked;
        out_src_d  = grant_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;

endmodule
